// File: rtl/instr_readback.sv
// Readback scanner for the 32-entry instruction register: fetches a range of entries,
// recomputes each result from opcode/operands and streams entry + mismatch flag downstream.
package instr_readback_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_r;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    operand_r res;
  } instruction_t;
endpackage

module instr_readback
  import instr_readback_pkg::*;
#(
  parameter int ERR_W = 8,
  parameter int DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  address_t           start_ptr,
  input  logic [5:0]         count,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_instr,
  output address_t           out_index,
  output operand_r           out_expected,
  output logic               out_mismatch,
  output logic               out_div0,
  output logic               busy,
  output logic               done,
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CHECK   = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [5:0] MAX_COUNT = 6'(DEPTH);
  localparam address_t   LAST_ADDR = address_t'(DEPTH - 1);

  state_t             state_reg, state_next;
  address_t           ptr_reg;
  logic [5:0]         remaining_reg;
  instruction_t       iw_reg;
  address_t           index_reg;
  operand_r           expected_reg;
  logic               mismatch_reg;
  logic               div0_reg;
  logic [ERR_W-1:0]   err_reg;

  logic               handshake;
  operand_r           a_ext, b_ext;
  operand_r           calc_expected;
  logic               calc_div0;
  logic               calc_mismatch;
  address_t           ptr_inc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) state_next = (count == 6'd0) ? FINISH : FETCH;
      end
      FETCH:   state_next = CHECK;
      CHECK:   state_next = PRESENT;
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = (remaining_reg == 6'd1) ? FINISH : FETCH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign handshake = (state_reg == PRESENT) && out_ready;
  assign ptr_inc   = (ptr_reg == LAST_ADDR) ? '0 : ptr_reg + address_t'(1);

  // ------------------------------------------------- result recompute
  // Operands are widened to the result width first so products and quotients
  // match the write path, including the -2^31 / -1 corner.
  always_comb begin
    a_ext         = operand_r'(iw_reg.op_a);
    b_ext         = operand_r'(iw_reg.op_b);
    calc_expected = '0;
    calc_div0     = 1'b0;
    case (iw_reg.opc)
      ZERO:  calc_expected = '0;
      PASSA: calc_expected = a_ext;
      PASSB: calc_expected = b_ext;
      ADD:   calc_expected = a_ext + b_ext;
      SUB:   calc_expected = a_ext - b_ext;
      MULT:  calc_expected = a_ext * b_ext;
      DIV: begin
        if (iw_reg.op_b == '0) calc_div0 = 1'b1;
        else                   calc_expected = a_ext / b_ext;
      end
      MOD: begin
        if (iw_reg.op_b == '0) calc_div0 = 1'b1;
        else                   calc_expected = a_ext % b_ext;
      end
      default: calc_expected = '0;
    endcase
    calc_mismatch = !calc_div0 && (calc_expected != iw_reg.res);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_reg       <= '0;
      remaining_reg <= '0;
      iw_reg        <= '0;
      index_reg     <= '0;
      expected_reg  <= '0;
      mismatch_reg  <= 1'b0;
      div0_reg      <= 1'b0;
      err_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && count != 6'd0) begin
            ptr_reg       <= start_ptr;
            remaining_reg <= (count > MAX_COUNT) ? MAX_COUNT : count;
          end
        end
        FETCH: begin
          iw_reg    <= instruction_word;
          index_reg <= ptr_reg;
        end
        CHECK: begin
          expected_reg <= calc_expected;
          mismatch_reg <= calc_mismatch;
          div0_reg     <= calc_div0;
        end
        PRESENT: begin
          if (handshake) begin
            if (mismatch_reg && err_reg != '1) err_reg <= err_reg + 1'b1;
            if (remaining_reg > 6'd1) begin
              remaining_reg <= remaining_reg - 6'd1;
              ptr_reg       <= ptr_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign read_pointer = ptr_reg;
  assign out_instr    = iw_reg;
  assign out_index    = index_reg;
  assign out_expected = expected_reg;
  assign out_mismatch = mismatch_reg;
  assign out_div0     = div0_reg;
  assign err_count    = err_reg;

endmodule

// File: tb/tb_instr_readback.sv
// Bench for instr_readback: register array model, directed scans plus randomized contents/backpressure.
module tb_instr_readback;
  import instr_readback_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  address_t     start_ptr = '0;
  logic [5:0]   count = '0;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready = 1'b0;
  instruction_t out_instr;
  address_t     out_index;
  operand_r     out_expected;
  logic         out_mismatch, out_div0, busy, done;
  logic [7:0]   err_count;

  instruction_t mem [32];
  int errors = 0;
  int checks = 0;
  int err_model = 0;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_readback #(.ERR_W(8), .DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ptr(start_ptr), .count(count),
    .read_pointer(read_pointer), .instruction_word(instruction_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_index(out_index), .out_expected(out_expected), .out_mismatch(out_mismatch),
    .out_div0(out_div0), .busy(busy), .done(done), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference at full result width
  function automatic void ref_model(input instruction_t iw, output operand_r e, output logic d0);
    longint a, b;
    a  = longint'(iw.op_a);
    b  = longint'(iw.op_b);
    d0 = 1'b0;
    e  = 0;
    case (iw.opc)
      PASSA: e = a;
      PASSB: e = b;
      ADD:   e = a + b;
      SUB:   e = a - b;
      MULT:  e = a * b;
      DIV:   if (b == 0) d0 = 1'b1; else e = a / b;
      MOD:   if (b == 0) d0 = 1'b1; else e = a % b;
      default: e = 0;
    endcase
  endfunction

  function automatic instruction_t mk(input opcode_t o, input int a, input int b,
                                      input bit corrupt, input longint bad_res);
    instruction_t t;
    operand_r e;
    logic d;
    t.opc  = o;
    t.op_a = a;
    t.op_b = b;
    t.res  = '0;
    ref_model(t, e, d);
    t.res = corrupt ? bad_res : (d ? 0 : e);
    return t;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rptr"}, read_pointer, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_exp"}, out_expected, 0);
    chk({tag, "_opc"}, out_instr.opc, 0);
    chk({tag, "_mm"}, out_mismatch, 0);
    chk({tag, "_div0"}, out_div0, 0);
  endtask

  // One complete scan with scoreboard; outputs sampled on the falling edge
  task automatic run_scan(input int sp, input int cnt, input int ready_pct,
                          input int stall, input bit poke_start);
    int n, cyc, first_valid, done_cyc, last_hs_cyc, stall_left, idx;
    int q[$];
    operand_r e;
    logic d0, mm;
    n = (cnt > 32) ? 32 : cnt;
    first_valid = -1; done_cyc = -1; last_hs_cyc = -1; stall_left = stall;
    for (int i = 0; i < n; i++) q.push_back((sp + i) % 32);

    @(negedge clk);
    start = 1'b1; start_ptr = address_t'(sp); count = 6'(cnt); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (n != 0) chk("ptr_load", read_pointer, sp);
    chk("busy_start", busy, 1);

    while (cyc < 4000) begin
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        chk("valid_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          idx = q[0];
          ref_model(mem[idx], e, d0);
          mm = !d0 && (e != mem[idx].res);
          chk("out_index", out_index, idx);
          chk("out_instr_a", out_instr.op_a, mem[idx].op_a);
          chk("out_instr_res", out_instr.res, mem[idx].res);
          chk("out_expected", out_expected, e);
          chk("out_mismatch", out_mismatch, mm);
          chk("out_div0", out_div0, d0);
          chk("ptr_hold", read_pointer, idx);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          if (poke_start && stall_left == 5) start = 1'b1;
        end else begin
          out_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (out_ready && q.size() != 0) begin
          $display("entry idx=%0d opc=%s exp=%0d mm=%0b div0=%0b", idx, mem[idx].opc.name(), e, mm, d0);
          if (mm && err_model < 255) err_model++;
          void'(q.pop_front());
          last_hs_cyc = cyc + 1;
        end
      end else begin
        out_ready = $urandom_range(0, 1);
      end
      @(negedge clk);
      cyc++;
    end

    start = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("queue_empty", q.size(), 0);
    if (n == 0) begin
      chk("done_lat_count0", done_cyc, 1);
      chk("no_valid_count0", first_valid, -1);
    end else begin
      chk("done_after_hs", done_cyc, last_hs_cyc);
      if (ready_pct == 100 && stall == 0) begin
        chk("first_valid_lat", first_valid, 3);
        chk("scan_len", done_cyc, 3 * n + 1);
      end
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("idle_no_valid", out_valid, 0);
    chk("err_count", err_count, err_model);
    $display("scan start=%0d count=%0d entries=%0d done_cyc=%0d err_count=%0d", sp, cnt, n, done_cyc, err_count);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Single ADD entry
    mem[3] = mk(ADD, 5, 7, 1'b0, 0);
    run_scan(3, 1, 100, 0, 1'b0);

    // Wrap-around 30, 31, 0
    mem[30] = mk(SUB, 9, 4, 1'b0, 0);
    mem[31] = mk(MULT, 3, 6, 1'b0, 0);
    mem[0]  = mk(PASSB, 1, 8, 1'b0, 0);
    run_scan(30, 3, 100, 0, 1'b0);

    // Divide by zero skips the comparison
    mem[2] = mk(DIV, 9, 0, 1'b0, 0);
    run_scan(2, 1, 100, 0, 1'b0);

    // Corrupted load: stored 10 instead of 12
    mem[5] = mk(ADD, 5, 7, 1'b1, 10);
    run_scan(5, 1, 100, 0, 1'b0);

    // Backpressure for 10 cycles with a stray start
    run_scan(28, 6, 100, 10, 1'b1);

    // count = 0
    run_scan(7, 0, 100, 0, 1'b0);

    // Randomized contents, clamp of count 40, random ready
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        opcode_t o;
        int a, b;
        o = opcode_t'($urandom_range(0, 7));
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 200) - 100;
        mem[i] = mk(o, a, b, ($urandom_range(0, 3) == 0), longint'($urandom));
      end
      if (r == 0) run_scan($urandom_range(0, 31), 40, 100, 0, 1'b0);
      else        run_scan($urandom_range(0, 31), $urandom_range(1, 63), 60, 0, 1'b0);
    end

    // Reset in the middle of a scan
    @(negedge clk);
    start = 1'b1; start_ptr = 5'd10; count = 6'd5; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    reset_n = 1'b0;
    err_model = 0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
